// File: rtl/data_mover_sched_if.sv
// ---------------------------------------------------------------------------
// data_mover_sched_if
//   Bundles the scheduler's requester-side and mover-side signals.
//
//   Requester side : i_req, i_num_cnt, i_timeout  -> scheduler
//                    o_ack, o_done, o_err, o_busy, o_owner <- scheduler
//   Mover side     : o_run, o_num_cnt             -> mover i_run/i_num_cnt
//                    i_idle, i_done               <- mover o_idle/o_done
//
//   modport slave  : the scheduler's view.
//   modport master : the environment's view (host control plus mover).
// ---------------------------------------------------------------------------
interface data_mover_sched_if #(
  parameter int IDW    = 2,
  parameter int AWIDTH = 12,
  parameter int TW     = 16
);
  localparam int NUM_REQ = 1 << IDW;

  // requester side
  logic [NUM_REQ-1:0]        i_req;
  logic [NUM_REQ*AWIDTH-1:0] i_num_cnt;
  logic [TW-1:0]             i_timeout;
  logic [NUM_REQ-1:0]        o_ack;
  logic [NUM_REQ-1:0]        o_done;
  logic [NUM_REQ-1:0]        o_err;
  logic                      o_busy;
  logic [IDW-1:0]            o_owner;

  // mover side
  logic                      o_run;
  logic [AWIDTH-1:0]         o_num_cnt;
  logic                      i_idle;
  logic                      i_done;

  modport slave (
    input  i_req, i_num_cnt, i_timeout, i_idle, i_done,
    output o_ack, o_done, o_err, o_busy, o_owner, o_run, o_num_cnt
  );

  modport master (
    output i_req, i_num_cnt, i_timeout, i_idle, i_done,
    input  o_ack, o_done, o_err, o_busy, o_owner, o_run, o_num_cnt
  );
endinterface

// File: rtl/data_mover_sched.sv
// ---------------------------------------------------------------------------
// data_mover_sched
//   Round-robin scheduler sharing one BRAM copy engine among NUM_REQ
//   requesters. A winner's count is latched, the mover is kicked with a
//   one-cycle run pulse, and the scheduler waits for the mover's done. A
//   watchdog reports a stuck transfer through o_err and then drains until the
//   mover settles, since the mover itself cannot be aborted.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high
//   bus    - data_mover_sched_if.slave
//            i_req/i_num_cnt/i_timeout : requests, packed counts, watchdog
//            o_ack/o_done/o_err        : one-hot single-cycle pulses
//            o_busy/o_owner            : status
//            o_run/o_num_cnt           : to the mover
//            i_idle/i_done             : from the mover
//
// Timing: o_ack is asserted in the IDLE cycle that makes the grant, so o_run
// (decoded from LAUNCH) follows one cycle later. o_err is asserted in the WAIT
// cycle where the watchdog expires; o_done is decoded from FIN, the cycle
// after the mover's done.
// ---------------------------------------------------------------------------
module data_mover_sched #(
  parameter int IDW    = 2,
  parameter int AWIDTH = 12,
  parameter int TW     = 16
) (
  input  logic               clk,
  input  logic               reset,
  data_mover_sched_if.slave  bus
);
  localparam int NUM_REQ = 1 << IDW;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_FIN    = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;

  logic [2:0]        state;
  logic [IDW-1:0]    last;     // most recently served requester
  logic [IDW-1:0]    owner;
  logic [AWIDTH-1:0] cnt;
  logic [TW-1:0]     wd;

  logic [IDW-1:0]    win;
  logic              win_vld;
  logic [IDW-1:0]    cand;
  logic [AWIDTH-1:0] win_cnt;
  logic              grant;
  logic              wd_hit;

  // Round-robin search starting just after the last served id. The IDW-bit
  // sum wraps naturally, giving the modulo-NUM_REQ order; i == NUM_REQ
  // lands back on 'last' itself, which is lowest priority.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = last + IDW'(i);
      if (!win_vld && bus.i_req[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  assign win_cnt = bus.i_num_cnt[int'(win)*AWIDTH +: AWIDTH];
  assign grant   = (state == S_IDLE) && bus.i_idle && win_vld;

  // Watchdog expiry; a zero limit disables it.
  assign wd_hit  = (bus.i_timeout != '0) && (wd == bus.i_timeout - TW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      last  <= IDW'(NUM_REQ - 1);
      owner <= '0;
      cnt   <= '0;
      wd    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant) begin
            owner <= win;
            cnt   <= win_cnt;
            // A zero count would make the mover run a full 2**AWIDTH
            // transfer, so it is completed without touching the mover.
            state <= (win_cnt == '0) ? S_FIN : S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          wd    <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (wd != '1) wd <= wd + TW'(1);
          if (bus.i_done)  state <= S_FIN;
          else if (wd_hit) state <= S_DRAIN;
        end
        S_FIN: begin
          last  <= owner;
          state <= S_IDLE;
        end
        S_DRAIN: begin
          // Timed-out transfer is never reported done; just wait for the
          // mover to settle before arbitrating again.
          if (bus.i_done || bus.i_idle) begin
            last  <= owner;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // o_ack is gated by reset so the combinational grant path cannot leak out
  // while the block is held in reset.
  assign bus.o_ack     = (grant && !reset) ? (NUM_REQ'(1) << win) : '0;
  // i_done wins over a same-cycle watchdog expiry.
  assign bus.o_err     = (state == S_WAIT && !bus.i_done && wd_hit)
                         ? (NUM_REQ'(1) << owner) : '0;
  assign bus.o_done    = (state == S_FIN) ? (NUM_REQ'(1) << owner) : '0;
  assign bus.o_run     = (state == S_LAUNCH);
  assign bus.o_busy    = (state != S_IDLE);
  assign bus.o_owner   = owner;
  assign bus.o_num_cnt = cnt;

endmodule

// File: tb/tb_data_mover_sched.sv
module tb_data_mover_sched;
  localparam int IDW     = 2;
  localparam int AWIDTH  = 12;
  localparam int TW      = 16;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;
  int   runs, errs, dones, acks;
  int   order [5] = '{0, 1, 2, 3, 0};

  data_mover_sched_if #(.IDW(IDW), .AWIDTH(AWIDTH), .TW(TW)) bus();

  data_mover_sched #(.IDW(IDW), .AWIDTH(AWIDTH), .TW(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] oh(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // ---------------- reset state ----------------
    reset         = 1'b1;
    bus.i_req     = '0;
    bus.i_num_cnt = '0;
    bus.i_timeout = '0;
    bus.i_idle    = 1'b1;
    bus.i_done    = 1'b0;
    tick(); tick();
    bus.i_req     = 4'b0001;
    bus.i_num_cnt = {12'd0, 12'd0, 12'd0, 12'd8};
    #1;
    chk("rst_ack",  bus.o_ack, 0);
    chk("rst_done", bus.o_done, 0);
    chk("rst_err",  bus.o_err, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_own",  bus.o_owner, 0);
    chk("rst_run",  bus.o_run, 0);
    chk("rst_cnt",  bus.o_num_cnt, 0);

    // ---------------- 1: single transfer ----------------
    reset = 1'b0;
    #1;
    chk("t1_ack", bus.o_ack, 4'b0001);
    tick();                                  // LAUNCH
    chk("t1_run",  bus.o_run, 1);
    chk("t1_own",  bus.o_owner, 0);
    chk("t1_cnt",  bus.o_num_cnt, 8);
    chk("t1_ack_off", bus.o_ack, 0);
    bus.i_req  = '0;
    bus.i_idle = 1'b0;
    runs = 0; dones = 0;
    repeat (15) begin
      tick();
      runs  += int'(bus.o_run);
      dones += int'(|bus.o_done);
    end
    bus.i_done = 1'b1;                       // 15 cycles after run
    #1;
    chk("t1_extra_run",  runs, 0);
    chk("t1_early_done", dones, 0);
    chk("t1_done_wait",  bus.o_done, 0);
    tick();                                  // FIN
    bus.i_done = 1'b0;
    bus.i_idle = 1'b1;
    chk("t1_done", bus.o_done, 4'b0001);
    chk("t1_busy_fin", bus.o_busy, 1);
    tick();
    chk("t1_done_off", bus.o_done, 0);
    chk("t1_busy_off", bus.o_busy, 0);
    chk("t1_cnt_hold", bus.o_num_cnt, 8);

    // ---------------- 2: round robin ----------------
    reset = 1'b1;
    #1;
    reset = 1'b0;
    bus.i_num_cnt = {12'd4, 12'd3, 12'd2, 12'd1};
    bus.i_req     = 4'b1111;
    bus.i_idle    = 1'b0;
    #1;
    chk("t2_noidle_ack", bus.o_ack, 0);
    tick();
    chk("t2_noidle_busy", bus.o_busy, 0);
    bus.i_idle = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t2_ack%0d", k), bus.o_ack, oh(order[k]));
      tick();                                // LAUNCH
      chk($sformatf("t2_run%0d", k), bus.o_run, 1);
      chk($sformatf("t2_own%0d", k), bus.o_owner, order[k]);
      chk($sformatf("t2_cnt%0d", k), bus.o_num_cnt, order[k] + 1);
      bus.i_idle = 1'b0;
      tick();                                // WAIT
      bus.i_done = 1'b1;
      bus.i_idle = 1'b1;
      chk($sformatf("t2_run_off%0d", k), bus.o_run, 0);
      tick();                                // FIN
      bus.i_done = 1'b0;
      chk($sformatf("t2_done%0d", k), bus.o_done, oh(order[k]));
      tick();                                // IDLE
    end

    // ---------------- 3: zero count ----------------
    bus.i_req = 4'b0100;
    bus.i_num_cnt[24 +: 12] = 12'd0;
    #1;
    chk("t3_ack", bus.o_ack, 4'b0100);
    tick();                                  // FIN directly
    chk("t3_run",  bus.o_run, 0);
    chk("t3_done", bus.o_done, 4'b0100);
    chk("t3_cnt",  bus.o_num_cnt, 0);
    bus.i_req = '0;
    tick();
    chk("t3_busy_off", bus.o_busy, 0);

    // ---------------- 4: timeout ----------------
    bus.i_timeout = 16'd20;
    bus.i_num_cnt[12 +: 12] = 12'd5;
    bus.i_req = 4'b0010;
    #1;
    chk("t4_ack", bus.o_ack, 4'b0010);
    tick();                                  // LAUNCH
    chk("t4_run", bus.o_run, 1);
    bus.i_req  = '0;
    bus.i_idle = 1'b0;
    errs = 0;
    repeat (19) begin
      tick();
      errs += int'(|bus.o_err);
    end
    chk("t4_early_err", errs, 0);
    tick();                                  // 20 cycles after LAUNCH
    chk("t4_err",  bus.o_err, 4'b0010);
    chk("t4_done_none", bus.o_done, 0);
    bus.i_req = 4'b1000;
    tick();                                  // DRAIN
    chk("t4_err_off", bus.o_err, 0);
    dones = 0; acks = 0;
    repeat (3) begin
      tick();
      dones += int'(|bus.o_done);
      acks  += int'(|bus.o_ack);
      chk("t4_drain_busy", bus.o_busy, 1);
    end
    chk("t4_drain_done", dones, 0);
    chk("t4_drain_ack",  acks, 0);
    bus.i_idle = 1'b1;
    tick();                                  // IDLE
    chk("t4_next_ack", bus.o_ack, 4'b1000);
    tick();                                  // LAUNCH
    chk("t4_next_own", bus.o_owner, 3);
    chk("t4_next_cnt", bus.o_num_cnt, 4);
    bus.i_req  = '0;
    bus.i_idle = 1'b0;

    // ---------------- 5: done on the expiry cycle ----------------
    repeat (19) tick();
    tick();
    bus.i_done = 1'b1;
    #1;
    chk("t5_err", bus.o_err, 0);
    tick();                                  // FIN
    bus.i_done = 1'b0;
    bus.i_idle = 1'b1;
    chk("t5_done", bus.o_done, 4'b1000);
    chk("t5_err_after", bus.o_err, 0);
    tick();
    chk("t5_busy_off", bus.o_busy, 0);

    // ---------------- 6: reset mid-WAIT ----------------
    bus.i_req = 4'b0010;
    #1;
    chk("t6_ack", bus.o_ack, 4'b0010);
    tick();                                  // LAUNCH
    bus.i_req  = '0;
    bus.i_idle = 1'b0;
    tick(); tick();                          // WAIT
    chk("t6_busy_wait", bus.o_busy, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_busy", bus.o_busy, 0);
    chk("t6_rst_own",  bus.o_owner, 0);
    chk("t6_rst_cnt",  bus.o_num_cnt, 0);
    chk("t6_rst_run",  bus.o_run, 0);
    chk("t6_rst_err",  bus.o_err, 0);
    chk("t6_rst_done", bus.o_done, 0);
    bus.i_req  = 4'b1001;
    bus.i_idle = 1'b1;
    #1;
    chk("t6_rst_ack", bus.o_ack, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("t6_ack_after", bus.o_ack, 4'b0001);
    tick();
    chk("t6_own_after", bus.o_owner, 0);
    chk("t6_cnt_after", bus.o_num_cnt, 1);
    chk("t6_run_after", bus.o_run, 1);
    bus.i_req = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
